// File: rtl/proc_ctrl_if.sv
// Bus between the processor controller and its datapath: fetch/run inputs and
// the per-cycle register, bus-driver and ALU controls.
interface proc_ctrl_if #(
  parameter int RSEL_W = 3
);
  localparam int NREG = 2 ** RSEL_W;
  localparam int IW   = 3 + 2 * RSEL_W;

  logic            Run;
  logic [IW-1:0]   DIN;
  logic            GNZ;
  logic            IRin;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;
  logic            Ain;
  logic            Gin;
  logic            Gout;
  logic            DINout;
  logic            AddSub;
  logic            Done;

  // master: datapath / stimulus side; slave: the controller
  modport master (
    output Run, DIN, GNZ,
    input  IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done
  );

  modport slave (
    input  Run, DIN, GNZ,
    output IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done
  );
endinterface

// File: rtl/proc_ctrl.sv
// T0-T3 control unit for the bus-based processor (mv, mvi, add, sub).
// Define PROC_CTRL_MVNZ_EN to enable opcode 100 as mvnz Rx,Ry (gated by GNZ).
module proc_ctrl #(
  parameter int RSEL_W = 3
) (
  input  logic        Clock,
  input  logic        Reset,
  proc_ctrl_if.slave  bus,
  output logic [1:0]  dbg_state
);
  localparam int NREG = 2 ** RSEL_W;
  localparam int IW   = 3 + 2 * RSEL_W;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
`ifdef PROC_CTRL_MVNZ_EN
  localparam logic [2:0] OP_MVNZ = 3'b100;
`endif

  localparam logic [NREG-1:0] ONE = NREG'(1);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [IW-1:0]     ir;
  logic [2:0]        op;
  logic [RSEL_W-1:0] rx;
  logic [RSEL_W-1:0] ry;
  logic [NREG-1:0]   sel_x;
  logic [NREG-1:0]   sel_y;

  logic            irin;
  logic [NREG-1:0] rin;
  logic [NREG-1:0] rout;
  logic            ain;
  logic            gin;
  logic            gout;
  logic            dinout;
  logic            addsub;
  logic            done;

`ifndef PROC_CTRL_MVNZ_EN
  logic unused_gnz;
  assign unused_gnz = bus.GNZ;
`endif

  assign op        = ir[IW-1 -: 3];
  assign rx        = ir[IW-4 -: RSEL_W];
  assign ry        = ir[RSEL_W-1:0];
  assign sel_x     = ONE << rx;
  assign sel_y     = ONE << ry;
  assign dbg_state = state;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == T0 && bus.Run) ir <= bus.DIN;
    end
  end

  always_comb begin
    state_next = state;
    irin   = 1'b0;
    rin    = '0;
    rout   = '0;
    ain    = 1'b0;
    gin    = 1'b0;
    gout   = 1'b0;
    dinout = 1'b0;
    addsub = 1'b0;
    done   = 1'b0;
    case (state)
      T0: begin
        irin = bus.Run;
        if (bus.Run) state_next = T1;
      end
      T1: begin
        state_next = T0;
        case (op)
          OP_MV: begin
            rout = sel_y;
            rin  = sel_x;
            done = 1'b1;
          end
          OP_MVI: begin
            dinout = 1'b1;
            rin    = sel_x;
            done   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout       = sel_x;
            ain        = 1'b1;
            state_next = T2;
          end
`ifdef PROC_CTRL_MVNZ_EN
          OP_MVNZ: begin
            if (bus.GNZ) begin
              rout = sel_y;
              rin  = sel_x;
            end
            done = 1'b1;
          end
`endif
          // Unknown opcodes retire as a single-cycle NOP
          default: done = 1'b1;
        endcase
      end
      T2: begin
        rout       = sel_y;
        gin        = 1'b1;
        addsub     = (op == OP_SUB);
        state_next = T3;
      end
      T3: begin
        gout       = 1'b1;
        rin        = sel_x;
        done       = 1'b1;
        state_next = T0;
      end
      default: state_next = T0;
    endcase
  end

  // Reset silences every control at once, even mid-instruction
  assign bus.IRin   = Reset ? 1'b0 : irin;
  assign bus.Rin    = Reset ? '0   : rin;
  assign bus.Rout   = Reset ? '0   : rout;
  assign bus.Ain    = Reset ? 1'b0 : ain;
  assign bus.Gin    = Reset ? 1'b0 : gin;
  assign bus.Gout   = Reset ? 1'b0 : gout;
  assign bus.DINout = Reset ? 1'b0 : dinout;
  assign bus.AddSub = Reset ? 1'b0 : addsub;
  assign bus.Done   = Reset ? 1'b0 : done;
endmodule

// File: tb/tb_proc_ctrl.sv
// Bench for proc_ctrl: per-cycle comparison against a micro-op schedule model,
// directed literal checks from hand-worked cases, then random instruction streams.
module tb_proc_ctrl;
  logic       Clock;
  logic       Reset;
  logic [1:0] dbg_state;

  proc_ctrl_if #(.RSEL_W(3)) bus ();

  proc_ctrl #(.RSEL_W(3)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int compared;
  int mismatched;

  // Output vector: {IRin, Rin[7:0], Rout[7:0], Ain, Gin, Gout, DINout, AddSub, Done}
  logic [22:0] outs;
  assign outs = {bus.IRin, bus.Rin, bus.Rout, bus.Ain, bus.Gin, bus.Gout,
                 bus.DINout, bus.AddSub, bus.Done};

  function automatic logic [22:0] pack(input logic irin, input logic [7:0] rin,
                                       input logic [7:0] rout, input logic ain,
                                       input logic gin, input logic gout,
                                       input logic dinout, input logic addsub,
                                       input logic done);
    return {irin, rin, rout, ain, gin, gout, dinout, addsub, done};
  endfunction

  // ---------------- model ----------------
  // Each fetched instruction expands into a list of micro-op steps (1 for
  // single-cycle ops, 3 for add/sub). Queue entry = {step[1:0], instr[8:0]}.
  logic [10:0] exp_q[$];

  function automatic int n_steps(input logic [8:0] instr);
    return (instr[8:6] == 3'd2 || instr[8:6] == 3'd3) ? 3 : 1;
  endfunction

  function automatic logic [22:0] micro_op(input logic [8:0] instr,
                                           input logic [1:0] stp, input logic gnz);
    logic [7:0] one;
    logic [7:0] rx;
    logic [7:0] ry;
    logic [2:0] op;
    one = 8'd1;
    op  = instr[8:6];
    rx  = one << instr[5:3];
    ry  = one << instr[2:0];
    if (stp == 2'd1) begin
      if (op == 3'd0)                   return pack(0, rx, ry, 0, 0, 0, 0, 0, 1);
      if (op == 3'd1)                   return pack(0, rx, 0, 0, 0, 0, 1, 0, 1);
      if (op == 3'd2 || op == 3'd3)     return pack(0, 0, rx, 1, 0, 0, 0, 0, 0);
`ifdef PROC_CTRL_MVNZ_EN
      if (op == 3'd4 && gnz)            return pack(0, rx, ry, 0, 0, 0, 0, 0, 1);
`else
      if (gnz && 1'b0)                  return '0;
`endif
      return pack(0, 0, 0, 0, 0, 0, 0, 0, 1);
    end
    if (stp == 2'd2) return pack(0, 0, ry, 0, 1, 0, 0, op == 3'd3, 0);
    return pack(0, rx, 0, 0, 0, 1, 0, 0, 1);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge Clock) begin : compare
    logic [22:0] expv;
    logic [10:0] e;
    if (Reset) begin
      expv = '0;
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      expv = micro_op(e[8:0], e[10:9], bus.GNZ);
    end else begin
      expv = pack(bus.Run, 0, 0, 0, 0, 0, 0, 0, 0);
      if (bus.Run)
        for (int s = 1; s <= n_steps(bus.DIN); s++) exp_q.push_back({2'(s), bus.DIN});
    end
    compared++;
    if (outs !== expv) begin
      mismatched++;
      $display("FAIL model_cycle t=%0t got=%b expected=%b", $time, outs, expv);
    end
    compared++;
    if ($countones({bus.Rout, bus.Gout, bus.DINout}) > 1 || $countones(bus.Rin) > 1 ||
        (bus.AddSub && !bus.Gin)) begin
      mismatched++;
      $display("FAIL exclusive t=%0t got=%b expected at most one driver/load", $time, outs);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic look();
    @(negedge Clock);
    #2;
  endtask

  task automatic lit(input string name, input logic [22:0] expv);
    compared++;
    if (outs !== expv) begin
      mismatched++;
      $display("FAIL %s got=%b expected=%b", name, outs, expv);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset   = 1'b1;
    bus.Run = 1'b1;
    bus.DIN = 9'b010001010;
    bus.GNZ = 1'b0;
    look();
    lit("reset_outputs", '0);
    step();
    look();
    lit("reset_hold", '0);

    // mvi R3
    step(); Reset = 1'b0; bus.Run = 1'b1; bus.DIN = 9'b001011000;
    look(); lit("t0_irin", pack(1, 0, 0, 0, 0, 0, 0, 0, 0));
    step(); bus.Run = 1'b0; bus.DIN = 9'h0a5;
    look(); lit("mvi_r3", pack(0, 8'b00001000, 0, 0, 0, 0, 1, 0, 1));
    step();
    look(); lit("idle_after_mvi", '0);

    // add R1,R2
    step(); bus.Run = 1'b1; bus.DIN = 9'b010001010;
    look();
    step(); bus.Run = 1'b0;
    look(); lit("add_t1", pack(0, 0, 8'b00000010, 1, 0, 0, 0, 0, 0));
    step();
    look(); lit("add_t2", pack(0, 0, 8'b00000100, 0, 1, 0, 0, 0, 0));
    step();
    look(); lit("add_t3", pack(0, 8'b00000010, 0, 0, 0, 1, 0, 0, 1));

    // sub R7,R0 with Run held high, second sub aborted by reset in T2
    step(); bus.Run = 1'b1; bus.DIN = 9'b011111000;
    look();
    step(); look(); lit("sub_t1", pack(0, 0, 8'b10000000, 1, 0, 0, 0, 0, 0));
    step(); look(); lit("sub_t2", pack(0, 0, 8'b00000001, 0, 1, 0, 0, 1, 0));
    step(); look(); lit("sub_t3", pack(0, 8'b10000000, 0, 0, 0, 1, 0, 0, 1));
    step(); look(); lit("sub_refetch", pack(1, 0, 0, 0, 0, 0, 0, 0, 0));
    step(); look();
    step(); Reset = 1'b1;
    look(); lit("reset_mid_t2", '0);
    step(); Reset = 1'b0; bus.Run = 1'b1; bus.DIN = 9'b001000000;
    look(); lit("post_reset_fetch", pack(1, 0, 0, 0, 0, 0, 0, 0, 0));
    step(); bus.Run = 1'b0;
    look(); lit("mvi_r0", pack(0, 8'b00000001, 0, 0, 0, 0, 1, 0, 1));

    // mvnz R5,R6
    step(); bus.Run = 1'b1; bus.DIN = 9'b100101110; bus.GNZ = 1'b0;
    look();
    step(); bus.Run = 1'b0;
    look(); lit("mvnz_gnz0", pack(0, 0, 0, 0, 0, 0, 0, 0, 1));
    step(); bus.Run = 1'b1; bus.GNZ = 1'b1;
    look();
    step(); bus.Run = 1'b0;
`ifdef PROC_CTRL_MVNZ_EN
    look(); lit("mvnz_gnz1", pack(0, 8'b00100000, 8'b01000000, 0, 0, 0, 0, 0, 1));
`else
    look(); lit("mvnz_disabled", pack(0, 0, 0, 0, 0, 0, 0, 0, 1));
`endif

    // illegal opcode
    step(); bus.Run = 1'b1; bus.DIN = 9'b111000000; bus.GNZ = 1'b0;
    look();
    step(); bus.Run = 1'b0;
    look(); lit("illegal_nop", pack(0, 0, 0, 0, 0, 0, 0, 0, 1));
    step();
    look(); lit("illegal_idle", '0);

    // mv R4,R4
    step(); bus.Run = 1'b1; bus.DIN = 9'b000100100;
    look();
    step(); bus.Run = 1'b0;
    look(); lit("mv_same_reg", pack(0, 8'b00010000, 8'b00010000, 0, 0, 0, 0, 0, 1));

    // random instruction streams with occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      step();
      Reset   = ($urandom_range(0, 39) == 0);
      bus.Run = 1'($urandom_range(0, 1));
      bus.DIN = 9'($urandom_range(0, 511));
      bus.GNZ = 1'($urandom_range(0, 1));
      look();
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/proc_ctrl.md
Name: proc_ctrl

Overview:
- Control unit for the 8-register bus-based processor datapath built from enabled registers (R0..R7, A, G, IR).
- Fetches a 9-bit instruction from DIN on a Run request and walks a T0–T3 state machine.
- Each cycle it drives the register load enables, the bus-driver selects and the ALU add/sub control.
- Asserts Done for one cycle when the instruction retires.

Parameters:
- RSEL_W, 3, width of a register-select field; NREG = 2**RSEL_W registers.
- IW, 3+2*RSEL_W (9), instruction width; format is III XXX YYY (opcode, Rx, Ry), MSB first.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Run  input  1  start request; sampled only in T0.
- DIN  input  IW  instruction word; loaded into IR in T0 when Run=1.
- GNZ  input  1  high when G register is nonzero; used only by mvnz.
- IRin  output  1  IR load enable.
- Rin  output  NREG  one-hot (or zero) load enable for R0..R(NREG-1).
- Rout  output  NREG  one-hot (or zero) bus-drive select for R0..R(NREG-1).
- Ain  output  1  A register load enable.
- Gin  output  1  G register load enable.
- Gout  output  1  G drives bus.
- DINout  output  1  DIN drives bus.
- AddSub  output  1  ALU op; 0=add, 1=sub.
- Done  output  1  instruction complete; one-cycle pulse.

Behaviour:
- Internal state: 2-bit state register (T0, T1, T2, T3) and IW-bit internal IR copy. Both are reset asynchronously to T0 and 0.
- All outputs are combinational from state, internal IR, Run and GNZ.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub. 100 is mvnz (see Optional Feature). Everything else is illegal.
- T0: IRin=Run; every other output is 0. If Run=1, load IR from DIN and go to T1; otherwise stay in T0.
- T1, mv: Rout[Y]=1, Rin[X]=1, Done=1; go to T0.
- T1, mvi: DINout=1, Rin[X]=1, Done=1; go to T0. The immediate is presented on DIN during T1.
- T1, add/sub: Rout[X]=1, Ain=1; go to T2.
- T1, illegal: Done=1 and nothing else; go to T0 (one-cycle NOP).
- T2, add/sub: Rout[Y]=1, Gin=1, AddSub = (op==sub); go to T3.
- T3, add/sub: Gout=1, Rin[X]=1, Done=1; go to T0.
- Latency from the Run-sample edge: mv/mvi/illegal, Done in the next cycle; add/sub, Done three cycles later.
- Invariant: at most one bus driver is active per cycle (Rout bits, Gout, DINout). Rin has at most one bit set. AddSub=0 outside T2.
- Run is ignored in T1–T3; holding Run high starts a new fetch in the T0 following Done. Back-to-back instructions therefore take one T0 cycle between them.
- X==Y is legal: mv Rx,Rx drives and loads the same register.
- Reset asserted in any state immediately forces every output to 0 and the state to T0. The aborted instruction produces no Done. The first cycle after deassertion is T0.

Optional Feature:
- Macro: PROC_CTRL_MVNZ_EN.
- Defined: opcode 100 = mvnz Rx,Ry. In T1, if GNZ=1 then Rout[Y]=1 and Rin[X]=1; if GNZ=0 both are 0. Done=1 in either case, then go to T0.
- Not defined: opcode 100 is illegal (NOP with Done in T1). GNZ remains a port but is ignored.

Test Plan:
- Reset: Reset=1 with Run=1 and DIN=9'b010001010 → all outputs 0. After release, T0 with IRin=1 and no Done until an instruction retires.
- mvi R3: Run=1, DIN=9'b001011000 → next cycle DINout=1, Rin=8'b00001000, Done=1. The following cycle (Run=0) has all outputs 0.
- add R1,R2: DIN=9'b010001010 → T1: Rout=8'b00000010, Ain=1. T2: Rout=8'b00000100, Gin=1, AddSub=0. T3: Gout=1, Rin=8'b00000010, Done=1.
- sub R7,R0 with Run held high: DIN=9'b011111000 → T2 AddSub=1, Done in T3. Assert Reset during a second sub's T2 → outputs 0 at once, no Done. After release, a fresh fetch occurs.
- mvnz R5,R6, DIN=9'b100101110, with PROC_CTRL_MVNZ_EN defined:
  - GNZ=0 → T1 Done=1, Rin=0, Rout=0.
  - GNZ=1 → Rin=8'b00100000, Rout=8'b01000000, Done=1.
  - Macro undefined → Done only.
- Illegal opcode 9'b111000000 → T1 Done=1, all other outputs 0, back to T0. A bus-driver exclusivity assertion holds over random instruction streams.
